// File: rtl/ikascc_plus_vrc.sv
// ikascc_plus_vrc: SCC-I (SCC+) cartridge mapper. Decodes the four 8 KiB bank
// windows at 4000h-BFFFh, holds the bank and BFFEh mode registers, opens the
// SCC (9800h) / SCC-I (B800h) register windows and produces the synchronised
// read/write requests used by the wavetable player.
module ikascc_plus_vrc #(
  parameter int unsigned BANK_BITS   = 6,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          SCCI_EN     = 1'b1
) (
  input  logic                 i_EMUCLK,
  input  logic                 i_RST,
  input  logic                 i_MCLK_PCEN_n,
  input  logic                 i_CS_n,
  input  logic                 i_RD_n,
  input  logic                 i_WR_n,
  input  logic [4:0]           i_ABHI,
  input  logic [7:0]           i_ABLO,
  input  logic [7:0]           i_DB,
  output logic                 o_ROMCS_n,
  output logic [BANK_BITS-1:0] o_ROMADDR,
  output logic                 o_MEMWE_n,
  output logic                 o_SCCREG_EN,
  output logic                 o_SCCI_MODE,
  output logic                 o_RDRQ,
  output logic                 o_WRRQ
);

  localparam int unsigned SS = SYNC_STAGES;

  // Sync chains: bit 0 is the newest sample. valid_w marks samples taken
  // after reset so a strobe already low at reset release is not seen as a fall.
  logic [SS-1:0]        chain_w;
  logic [SS-1:0]        chain_r;
  logic [SS-1:0]        valid_w;
  logic [7:0]           mode_q;
  logic [BANK_BITS-1:0] bank_q [4];
  logic                 wrrq_q;
  logic                 rdrq_q;
  logic                 memwe_n_q;

  logic       en;
  logic [7:0] mode_eff;
  logic       in_win;
  logic [1:0] win_idx;
  logic       mode_addr;
  logic       bank_addr;
  logic       scc_open;
  logic       scci_open;
  logic       reg_win;
  logic [3:0] ram_map;
  logic       win_ram;
  logic       mem_wr_ok;
  logic       wrrq_nxt;
  logic       unused_bits;

  // Address decode and window qualification from current registers
  always_comb begin
    en        = ~i_MCLK_PCEN_n;
    mode_eff  = SCCI_EN ? mode_q : 8'h00;
    in_win    = (i_ABHI >= 5'h08) && (i_ABHI <= 5'h17);
    win_idx   = {i_ABHI[4], i_ABHI[2]};
    mode_addr = (i_ABHI == 5'h17) && (i_ABLO[7:1] == 7'h7F);
    bank_addr = in_win && (i_ABHI[1:0] == 2'b10);
    scc_open  = ~mode_eff[5] && (bank_q[2][5:0] == 6'h3F) && (i_ABHI == 5'h13);
    scci_open = SCCI_EN && mode_eff[5] && bank_q[3][BANK_BITS-1] &&
                (i_ABHI == 5'h17) && ~mode_addr;
    reg_win   = scc_open || scci_open;
    ram_map   = {mode_eff[4], mode_eff[2:0]} | {4{mode_eff[4]}};
    win_ram   = ram_map[win_idx];
    mem_wr_ok = in_win && win_ram && ~reg_win && ~mode_addr;
    wrrq_nxt  = chain_w[SS-1] && ~chain_w[SS-2] && valid_w[SS-1];
  end

  // Strobe synchronisers, request flags and mapper registers
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      chain_w   <= '1;
      chain_r   <= '1;
      valid_w   <= '0;
      wrrq_q    <= 1'b0;
      rdrq_q    <= 1'b0;
      memwe_n_q <= 1'b1;
      mode_q    <= 8'h00;
      for (int n = 0; n < 4; n++) bank_q[n] <= BANK_BITS'(n);
    end else if (en) begin
      chain_w   <= {chain_w[SS-2:0], i_CS_n | i_WR_n};
      chain_r   <= {chain_r[SS-2:0], i_CS_n | i_RD_n};
      valid_w   <= {valid_w[SS-2:0], 1'b1};
      wrrq_q    <= wrrq_nxt;
      rdrq_q    <= ~chain_r[0];
      memwe_n_q <= ~(wrrq_nxt && mem_wr_ok);
      if (wrrq_q) begin
        if (mode_addr) begin
          if (SCCI_EN) mode_q <= i_DB;
        end else if (bank_addr && ~win_ram) begin
          bank_q[win_idx] <= i_DB[BANK_BITS-1:0];
        end
      end
    end
  end

  assign o_WRRQ      = wrrq_q;
  assign o_RDRQ      = rdrq_q;
  assign o_MEMWE_n   = memwe_n_q;
  assign o_SCCI_MODE = mode_eff[5];
  assign o_SCCREG_EN = reg_win;
  assign o_ROMADDR   = in_win ? bank_q[win_idx] : '0;
  assign o_ROMCS_n   = ~(~i_CS_n && in_win && ~reg_win && (~i_RD_n || ~memwe_n_q));

  assign unused_bits = ^{i_ABLO[0], chain_r[SS-1:1], mode_eff[7:6], mode_eff[3]};

endmodule

// File: tb/tb_ikascc_plus_vrc.sv
// Bench for ikascc_plus_vrc: directed scenarios with literal expectations,
// then randomised bus cycles and enable patterns against a sample-history model.
module tb_ikascc_plus_vrc;

  localparam int S  = 2;
  localparam int BB = 6;

  logic          emuclk = 1'b0;
  logic          rst    = 1'b1;
  logic          pcen_n = 1'b0;
  logic          cs_n   = 1'b1;
  logic          rd_n   = 1'b1;
  logic          wr_n   = 1'b1;
  logic [4:0]    abhi   = 5'h00;
  logic [7:0]    ablo   = 8'h00;
  logic [7:0]    db     = 8'h00;
  logic          romcs_n, memwe_n, sccreg_en, scci_mode, rdrq, wrrq;
  logic [BB-1:0] romaddr;
  logic          romcs_n2, memwe_n2, sccreg_en2, scci_mode2, rdrq2, wrrq2;
  logic [BB-1:0] romaddr2;

  int  nchk = 0;
  int  nerr = 0;
  bit  rand_en = 1'b0;

  ikascc_plus_vrc #(.BANK_BITS(BB), .SYNC_STAGES(S), .SCCI_EN(1'b1)) u_dut (
    .i_EMUCLK(emuclk), .i_RST(rst), .i_MCLK_PCEN_n(pcen_n), .i_CS_n(cs_n),
    .i_RD_n(rd_n), .i_WR_n(wr_n), .i_ABHI(abhi), .i_ABLO(ablo), .i_DB(db),
    .o_ROMCS_n(romcs_n), .o_ROMADDR(romaddr), .o_MEMWE_n(memwe_n),
    .o_SCCREG_EN(sccreg_en), .o_SCCI_MODE(scci_mode), .o_RDRQ(rdrq), .o_WRRQ(wrrq));

  ikascc_plus_vrc #(.BANK_BITS(BB), .SYNC_STAGES(S), .SCCI_EN(1'b0)) u_nosi (
    .i_EMUCLK(emuclk), .i_RST(rst), .i_MCLK_PCEN_n(pcen_n), .i_CS_n(cs_n),
    .i_RD_n(rd_n), .i_WR_n(wr_n), .i_ABHI(abhi), .i_ABLO(ablo), .i_DB(db),
    .o_ROMCS_n(romcs_n2), .o_ROMADDR(romaddr2), .o_MEMWE_n(memwe_n2),
    .o_SCCREG_EN(sccreg_en2), .o_SCCI_MODE(scci_mode2), .o_RDRQ(rdrq2), .o_WRRQ(wrrq2));

  always #5 emuclk = ~emuclk;

  task automatic check(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [7:0] m_mode;
  int       m_bank [4];
  bit       m_wrrq, m_rdrq, m_memwe_n, m_valid;
  bit       wq[$];
  bit       rq[$];

  function automatic bit m_inwin(input logic [4:0] hi);
    return (int'(hi) * 2048 >= 'h4000) && (int'(hi) * 2048 < 'hC000);
  endfunction

  function automatic int m_idx(input logic [4:0] hi);
    return (int'(hi) * 2048 - 'h4000) / 'h2000;
  endfunction

  function automatic bit m_modeaddr(input logic [4:0] hi, input logic [7:0] lo);
    return (hi == 5'h17) && (lo >= 8'hFE);
  endfunction

  function automatic bit m_ram(input int idx);
    return m_mode[4] || (idx < 3 && m_mode[idx]);
  endfunction

  function automatic bit m_regwin(input logic [4:0] hi, input logic [7:0] lo);
    bit scc, scci;
    scc  = !m_mode[5] && (m_bank[2] % 64 == 63) && (int'(hi) * 2048 == 'h9800);
    scci = m_mode[5] && (m_bank[3] >= (1 << (BB - 1))) && (int'(hi) * 2048 == 'hB800) &&
           !m_modeaddr(hi, lo);
    return scc || scci;
  endfunction

  // Model advance: a write lands at the enabled edge closing the request period
  always @(posedge emuclk) begin
    int n;
    if (rst) begin
      m_mode = 8'h00;
      for (int i = 0; i < 4; i++) m_bank[i] = i;
      m_wrrq = 0; m_rdrq = 0; m_memwe_n = 1;
      wq.delete(); rq.delete();
      m_valid = 1;
    end else if (!pcen_n) begin
      if (m_wrrq) begin
        if (m_modeaddr(abhi, ablo)) m_mode = db;
        else if (int'(abhi) * 2048 inside {'h5000, 'h7000, 'h9000, 'hB000}) begin
          if (!m_ram(m_idx(abhi))) m_bank[m_idx(abhi)] = int'(db) % (1 << BB);
        end
      end
      wq.push_back(cs_n | wr_n);
      rq.push_back(cs_n | rd_n);
      if (wq.size() > 8) void'(wq.pop_front());
      if (rq.size() > 8) void'(rq.pop_front());
      n = wq.size();
      m_wrrq = (n >= S + 1) && wq[n-1-S] && !wq[n-S];
      m_rdrq = (rq.size() >= 2) && !rq[rq.size()-2];
      m_memwe_n = !(m_wrrq && m_inwin(abhi) && m_ram(m_idx(abhi)) &&
                    !m_regwin(abhi, ablo) && !m_modeaddr(abhi, ablo));
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge emuclk) begin
    if (m_valid) begin
      bit win, rw;
      win = m_inwin(abhi);
      rw  = m_regwin(abhi, ablo);
      check("wrrq", wrrq, m_wrrq);
      check("rdrq", rdrq, m_rdrq);
      check("memwe_n", memwe_n, m_memwe_n);
      check("scci_mode", scci_mode, m_mode[5]);
      check("sccreg_en", sccreg_en, rw);
      check("romaddr", romaddr, win ? m_bank[m_idx(abhi)] : 0);
      check("romcs_n", romcs_n, !(!cs_n && win && !rw && (!rd_n || !m_memwe_n)));
      check("nosi_scci_mode", scci_mode2, 0);
      if (abhi == 5'h17) check("nosi_b800_closed", sccreg_en2, 0);
    end
  end

  // Enable generator: held active in directed phase, random afterwards
  always @(posedge emuclk) begin
    #1;
    pcen_n = rand_en ? ($urandom_range(0, 2) == 0) : 1'b0;
  end

  // ---------------- stimulus helpers ----------------
  task automatic en_tick(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge emuclk);
      if (!pcen_n) c++;
    end
    #1;
  endtask

  task automatic bus_wr(input logic [4:0] hi, input logic [7:0] lo, input logic [7:0] d,
                        input int hold);
    abhi = hi; ablo = lo; db = d; cs_n = 0; wr_n = 0;
    en_tick(hold);
    wr_n = 1; cs_n = 1;
    en_tick(S + 2);
  endtask

  task automatic rd_begin(input logic [4:0] hi, input logic [7:0] lo);
    abhi = hi; ablo = lo; cs_n = 0; rd_n = 0;
    #1;
  endtask

  task automatic rd_end();
    en_tick(2);
    rd_n = 1; cs_n = 1;
    en_tick(1);
  endtask

  function automatic logic [4:0] pick_hi();
    logic [4:0] t [10] = '{5'h08, 5'h0A, 5'h0C, 5'h0E, 5'h10, 5'h12, 5'h13, 5'h14, 5'h16, 5'h17};
    int r = $urandom_range(0, 11);
    return (r < 10) ? t[r] : 5'($urandom);
  endfunction

  initial begin : watchdog
    #2_000_000;
    nerr++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin : main
    int cnt, first;
    logic [7:0] modes [8] = '{8'h00, 8'h20, 8'h01, 8'h02, 8'h04, 8'h10, 8'h21, 8'h24};

    // Reset state
    repeat (3) @(posedge emuclk);
    #1 rst = 0;
    #1;
    check("rst_wrrq", wrrq, 0);
    check("rst_rdrq", rdrq, 0);
    check("rst_memwe_n", memwe_n, 1);
    check("rst_scci_mode", scci_mode, 0);
    check("rst_sccreg_en", sccreg_en, 0);

    // Default bank mapping 4000h/6000h/8000h/A000h -> 0,1,2,3
    for (int i = 0; i < 4; i++) begin
      rd_begin(5'(8 + 4 * i), 8'h00);
      check("dflt_romaddr", romaddr, i);
      check("dflt_romcs_n", romcs_n, 0);
      check("dflt_sccreg", sccreg_en, 0);
      rd_end();
    end

    // SCC window via bank2 = 3Fh, then closed again
    bus_wr(5'h12, 8'h00, 8'h3F, 4);
    rd_begin(5'h13, 8'h00);
    check("scc_open", sccreg_en, 1);
    check("scc_romcs_n", romcs_n, 1);
    rd_end();
    bus_wr(5'h12, 8'h00, 8'h00, 4);
    rd_begin(5'h13, 8'h00);
    check("scc_closed", sccreg_en, 0);
    check("scc_closed_romcs_n", romcs_n, 0);
    rd_end();

    // SCC-I window: mode 20h, bank3 top bit set (A0h -> 20h in 6 bits)
    bus_wr(5'h17, 8'hFE, 8'h20, 4);
    bus_wr(5'h16, 8'h00, 8'hA0, 4);
    rd_begin(5'h17, 8'h00);
    check("scci_mode_set", scci_mode, 1);
    check("scci_open", sccreg_en, 1);
    check("nosi_never_opens", sccreg_en2, 0);
    check("nosi_mode", scci_mode2, 0);
    rd_end();
    rd_begin(5'h17, 8'hFE);
    check("scci_bffe_closed", sccreg_en, 0);
    rd_end();

    // RAM bank0: write goes to memory (one MEMWE period), bank register untouched
    bus_wr(5'h17, 8'hFE, 8'h01, 4);
    abhi = 5'h0A; ablo = 8'h00; db = 8'h55; cs_n = 0; wr_n = 0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      en_tick(1);
      if (!memwe_n) cnt++;
    end
    wr_n = 1; cs_n = 1;
    en_tick(S + 2);
    check("ram_memwe_pulses", cnt, 1);
    rd_begin(5'h08, 8'h00);
    check("ram_bank0_kept", romaddr, 0);
    rd_end();
    bus_wr(5'h17, 8'hFE, 8'h00, 4);
    bus_wr(5'h0A, 8'h00, 8'h55, 4);
    rd_begin(5'h08, 8'h00);
    check("rom_bank0_written", romaddr, 'h15);
    rd_end();

    // /WR held low 10 periods: one request, S periods after the fall
    abhi = 5'h00; ablo = 8'h00; cs_n = 0; wr_n = 0;
    cnt = 0; first = -1;
    for (int i = 1; i <= 10; i++) begin
      en_tick(1);
      if (wrrq) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    wr_n = 1; cs_n = 1;
    en_tick(S + 2);
    check("hold_wrrq_count", cnt, 1);
    check("hold_wrrq_position", first, S);

    // Reset while /WR low: no request after release, registers at reset values
    abhi = 5'h0A; db = 8'h03; cs_n = 0; wr_n = 0;
    en_tick(1);
    rst = 1;
    repeat (2) @(posedge emuclk);
    #1 rst = 0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      en_tick(1);
      if (wrrq) cnt++;
    end
    wr_n = 1; cs_n = 1;
    en_tick(S + 2);
    check("rst_mid_no_wrrq", cnt, 0);
    rd_begin(5'h08, 8'h00);
    check("rst_mid_bank0", romaddr, 0);
    rd_end();
    rd_begin(5'h0C, 8'h00);
    check("rst_mid_bank1", romaddr, 1);
    rd_end();

    // Randomised phase against the model
    rand_en = 1'b1;
    for (int t = 0; t < 400; t++) begin
      int r;
      logic [4:0] hi;
      logic [7:0] lo, d;
      r  = $urandom_range(0, 19);
      hi = pick_hi();
      lo = ($urandom_range(0, 3) == 0) ? 8'(8'hFE + $urandom_range(0, 1)) : 8'($urandom);
      if (m_modeaddr(hi, lo)) d = modes[$urandom_range(0, 7)];
      else d = ($urandom_range(0, 2) == 0) ? 8'h3F : 8'($urandom);
      if (r < 9) bus_wr(hi, lo, d, $urandom_range(1, 6));
      else if (r < 18) begin
        abhi = hi; ablo = lo; cs_n = 0; rd_n = 0;
        en_tick($urandom_range(1, 5));
        rd_n = 1; cs_n = 1;
        en_tick(1);
      end else if (r == 18) begin
        rst = 1;
        repeat ($urandom_range(1, 2)) @(posedge emuclk);
        #1 rst = 0;
      end else en_tick($urandom_range(1, 4));
    end

    rand_en = 1'b0;
    en_tick(4);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
